// File: rtl/elevator_pkg.sv
// Shared types and helpers for the N-floor elevator controller.
// Holds the FSM state encoding, direction constants and counter sizing.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational SCAN look-up: pending requests above/below a floor and
// which requests at that floor are served given the travel direction.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4
) (
  input  logic [NUM_FLOORS-1:0] i_floor,
  input  logic                  i_dir_up,
  input  logic [NUM_FLOORS-1:0] i_car_pend,
  input  logic [NUM_FLOORS-1:0] i_up_pend,
  input  logic [NUM_FLOORS-1:0] i_dn_pend,
  output logic                  o_req_above,
  output logic                  o_req_below,
  output logic                  o_serve_here,
  output logic                  o_serve_up,
  output logic                  o_serve_dn,
  output logic                  o_flip
);

  int                    w_idx;
  logic [NUM_FLOORS-1:0] w_above_mask;
  logic [NUM_FLOORS-1:0] w_below_mask;
  logic [NUM_FLOORS-1:0] w_any;
  logic                  w_going_up;
  logic                  w_car_here;
  logic                  w_up_here;
  logic                  w_dn_here;

  always_comb begin
    w_idx        = 0;
    w_above_mask = '0;
    w_below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_floor[i]) w_idx = i;
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_above_mask[i] = (i > w_idx);
      w_below_mask[i] = (i < w_idx);
    end
  end

  assign w_any       = i_car_pend | i_up_pend | i_dn_pend;
  assign o_req_above = |(w_any & w_above_mask);
  assign o_req_below = |(w_any & w_below_mask);

  assign w_going_up = (i_dir_up == DIR_UP);
  assign w_car_here = |(i_car_pend & i_floor);
  assign w_up_here  = |(i_up_pend & i_floor);
  assign w_dn_here  = |(i_dn_pend & i_floor);

  // Opposite-direction hall calls are taken only when nothing lies further on.
  assign o_serve_up   = w_up_here & (w_going_up | ~o_req_below);
  assign o_serve_dn   = w_dn_here & (~w_going_up | ~o_req_above);
  assign o_serve_here = w_car_here | o_serve_up | o_serve_dn;
  assign o_flip       = w_going_up ? o_serve_dn : o_serve_up;

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latched requests, SCAN scheduling,
// cycle-counted floor travel and door dwell. All outputs are registered.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] i_car_call,
  input  logic [NUM_FLOORS-1:0] i_hall_up,
  input  logic [NUM_FLOORS-1:0] i_hall_dn,
  output logic [NUM_FLOORS-1:0] o_floor,
  output logic                  o_door_open,
  output logic                  o_moving,
  output logic                  o_dir_up,
  output logic [NUM_FLOORS-1:0] o_car_pend,
  output logic [NUM_FLOORS-1:0] o_up_pend,
  output logic [NUM_FLOORS-1:0] o_dn_pend,
  output state_t                o_state
);

  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = clog2(CMAX + 1);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [NUM_FLOORS-1:0] FLOOR0   = NUM_FLOORS'(1);

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_floor;
  logic                  r_dir_up;
  logic                  r_door_open;
  logic                  r_moving;
  logic [CW-1:0]         r_tcnt;
  logic [CW-1:0]         r_dcnt;
  logic [NUM_FLOORS-1:0] r_car_pend;
  logic [NUM_FLOORS-1:0] r_up_pend;
  logic [NUM_FLOORS-1:0] r_dn_pend;

  logic [NUM_FLOORS-1:0] w_floor_next;
  logic w_here_above, w_here_below, w_here_serve, w_here_up, w_here_dn, w_here_flip;
  logic w_next_above, w_next_below, w_next_serve, w_next_up, w_next_dn, w_next_flip;
  logic                  w_arrive;
  logic                  w_enter_door;
  logic                  w_in_door;
  logic                  w_srv_up;
  logic                  w_srv_dn;
  logic [NUM_FLOORS-1:0] w_door_floor;
  logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic [NUM_FLOORS-1:0] w_hit_car, w_hit_up, w_hit_dn;
  logic                  w_reload;

  // Direction is pinned at the shaft ends so the car can never leave 0..N-1.
  function automatic logic dir_at(input logic [NUM_FLOORS-1:0] fl, input logic d);
    if (fl[0]) return DIR_UP;
    if (fl[NUM_FLOORS-1]) return DIR_DN;
    return d;
  endfunction

  always_comb begin
    w_floor_next = r_floor;
    if (r_dir_up && !r_floor[NUM_FLOORS-1]) w_floor_next = r_floor << 1;
    else if (!r_dir_up && !r_floor[0])      w_floor_next = r_floor >> 1;
  end

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_here (
    .i_floor      (r_floor),
    .i_dir_up     (r_dir_up),
    .i_car_pend   (r_car_pend),
    .i_up_pend    (r_up_pend),
    .i_dn_pend    (r_dn_pend),
    .o_req_above  (w_here_above),
    .o_req_below  (w_here_below),
    .o_serve_here (w_here_serve),
    .o_serve_up   (w_here_up),
    .o_serve_dn   (w_here_dn),
    .o_flip       (w_here_flip)
  );

  // Evaluates the floor being arrived at so DOOR can start on the arrival edge.
  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_next (
    .i_floor      (w_floor_next),
    .i_dir_up     (r_dir_up),
    .i_car_pend   (r_car_pend),
    .i_up_pend    (r_up_pend),
    .i_dn_pend    (r_dn_pend),
    .o_req_above  (w_next_above),
    .o_req_below  (w_next_below),
    .o_serve_here (w_next_serve),
    .o_serve_up   (w_next_up),
    .o_serve_dn   (w_next_dn),
    .o_flip       (w_next_flip)
  );

  assign w_arrive     = (r_state == MOVE) && (r_tcnt == '0);
  assign w_enter_door = ((r_state == IDLE) && w_here_serve) || (w_arrive && w_next_serve);
  assign w_door_floor = (r_state == IDLE) ? r_floor : w_floor_next;
  assign w_srv_up     = (r_state == IDLE) ? w_here_up : w_next_up;
  assign w_srv_dn     = (r_state == IDLE) ? w_here_dn : w_next_dn;

  assign w_clr_car = w_enter_door ? w_door_floor : '0;
  assign w_clr_up  = (w_enter_door && w_srv_up) ? w_door_floor : '0;
  assign w_clr_dn  = (w_enter_door && w_srv_dn) ? w_door_floor : '0;

  // Presses at the open floor that would be served are absorbed into the dwell.
  assign w_in_door = (r_state == DOOR);
  assign w_hit_car = w_in_door ? (i_car_call & r_floor) : '0;
  assign w_hit_up  = (w_in_door && (r_dir_up || !w_here_below))
                     ? (i_hall_up & UP_VALID & r_floor) : '0;
  assign w_hit_dn  = (w_in_door && (!r_dir_up || !w_here_above))
                     ? (i_hall_dn & DN_VALID & r_floor) : '0;
  assign w_reload  = |{w_hit_car, w_hit_up, w_hit_dn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_car_pend <= '0;
      r_up_pend  <= '0;
      r_dn_pend  <= '0;
    end else begin
      r_car_pend <= (r_car_pend | (i_car_call & ~w_hit_car)) & ~w_clr_car;
      r_up_pend  <= (r_up_pend | (i_hall_up & UP_VALID & ~w_hit_up)) & ~w_clr_up;
      r_dn_pend  <= (r_dn_pend | (i_hall_dn & DN_VALID & ~w_hit_dn)) & ~w_clr_dn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_floor     <= FLOOR0;
      r_dir_up    <= DIR_UP;
      r_door_open <= 1'b0;
      r_moving    <= 1'b0;
      r_tcnt      <= '0;
      r_dcnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_here_serve) begin
            r_state     <= DOOR;
            r_door_open <= 1'b1;
            r_dcnt      <= DOOR_LOAD;
            r_dir_up    <= dir_at(r_floor, r_dir_up ^ w_here_flip);
          end else if (w_here_above || w_here_below) begin
            r_state  <= MOVE;
            r_moving <= 1'b1;
            r_tcnt   <= TRAVEL_LOAD;
            if (!(w_here_above && w_here_below))
              r_dir_up <= w_here_above ? DIR_UP : DIR_DN;
          end
        end
        MOVE: begin
          if (r_tcnt != '0) begin
            r_tcnt <= r_tcnt - CW'(1);
          end else begin
            r_floor <= w_floor_next;
            if (w_next_serve) begin
              r_state     <= DOOR;
              r_moving    <= 1'b0;
              r_door_open <= 1'b1;
              r_dcnt      <= DOOR_LOAD;
              r_dir_up    <= dir_at(w_floor_next, r_dir_up ^ w_next_flip);
            end else if (r_dir_up ? w_next_above : w_next_below) begin
              r_tcnt   <= TRAVEL_LOAD;
              r_dir_up <= dir_at(w_floor_next, r_dir_up);
            end else begin
              r_state  <= IDLE;
              r_moving <= 1'b0;
              r_dir_up <= dir_at(w_floor_next, r_dir_up);
            end
          end
        end
        DOOR: begin
          if (w_reload) begin
            r_dcnt <= DOOR_LOAD;
          end else if (r_dcnt == '0) begin
            r_state     <= IDLE;
            r_door_open <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt - CW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_door_open <= 1'b0;
          r_moving    <= 1'b0;
        end
      endcase
    end
  end

  assign o_floor     = r_floor;
  assign o_door_open = r_door_open;
  assign o_moving    = r_moving;
  assign o_dir_up    = r_dir_up;
  assign o_car_pend  = r_car_pend;
  assign o_up_pend   = r_up_pend;
  assign o_dn_pend   = r_dn_pend;
  assign o_state     = r_state;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: 4-floor main instance plus 2- and
// 8-floor instances for the shaft-end bounds.
module tb_elevator_ctrl_n;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] car_call = '0, hall_up = '0, hall_dn = '0;
  logic [3:0] floor, car_pend, up_pend, dn_pend;
  logic       door_open, moving, dir_up;
  state_t     state;

  logic [1:0] a2_car_call = '0, a2_hall_up = '0, a2_hall_dn = '0;
  logic [1:0] a2_floor, a2_car_pend, a2_up_pend, a2_dn_pend;
  logic       a2_door_open, a2_moving, a2_dir_up;
  state_t     a2_state;

  logic [7:0] a8_car_call = '0, a8_hall_up = '0, a8_hall_dn = '0;
  logic [7:0] a8_floor, a8_car_pend, a8_up_pend, a8_dn_pend;
  logic       a8_door_open, a8_moving, a8_dir_up;
  state_t     a8_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  elevator_ctrl_n #(.NUM_FLOORS(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_car_call(car_call), .i_hall_up(hall_up),
    .i_hall_dn(hall_dn), .o_floor(floor), .o_door_open(door_open),
    .o_moving(moving), .o_dir_up(dir_up), .o_car_pend(car_pend),
    .o_up_pend(up_pend), .o_dn_pend(dn_pend), .o_state(state)
  );

  elevator_ctrl_n #(.NUM_FLOORS(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_car_call(a2_car_call), .i_hall_up(a2_hall_up),
    .i_hall_dn(a2_hall_dn), .o_floor(a2_floor), .o_door_open(a2_door_open),
    .o_moving(a2_moving), .o_dir_up(a2_dir_up), .o_car_pend(a2_car_pend),
    .o_up_pend(a2_up_pend), .o_dn_pend(a2_dn_pend), .o_state(a2_state)
  );

  elevator_ctrl_n #(.NUM_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_car_call(a8_car_call), .i_hall_up(a8_hall_up),
    .i_hall_dn(a8_hall_dn), .o_floor(a8_floor), .o_door_open(a8_door_open),
    .o_moving(a8_moving), .o_dir_up(a8_dir_up), .o_car_pend(a8_car_pend),
    .o_up_pend(a8_up_pend), .o_dn_pend(a8_dn_pend), .o_state(a8_state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_door(input logic want, input string tag);
    int k;
    k = 0;
    while (door_open !== want && k < 200) begin
      tick(1);
      k++;
    end
    check(tag, door_open, want);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    // reset values
    tick(2);
    check("rst_floor", floor, 4'b0001);
    check("rst_door", door_open, 1'b0);
    check("rst_moving", moving, 1'b0);
    check("rst_dir", dir_up, 1'b1);
    check("rst_car_pend", car_pend, 4'b0000);
    check("rst_up_pend", up_pend, 4'b0000);
    check("rst_dn_pend", dn_pend, 4'b0000);
    check("rst_state", state, IDLE);
    check("rst_floor_n2", a2_floor, 2'b01);
    check("rst_floor_n8", a8_floor, 8'h01);
    rst_n = 1'b1;
    tick(1);

    // car call to floor 2 from floor 0
    car_call = 4'b0100;
    tick(1);
    car_call = '0;
    check("cc2_latched", car_pend, 4'b0100);
    check("cc2_not_moving_yet", moving, 1'b0);
    tick(1);
    check("cc2_moving", moving, 1'b1);
    check("cc2_floor_start", floor, 4'b0001);
    cnt = 1;
    while (moving && cnt < 40) begin
      tick(1);
      if (moving) cnt++;
    end
    check("cc2_travel_cycles", cnt, 8);
    check("cc2_floor", floor, 4'b0100);
    check("cc2_door", door_open, 1'b1);
    check("cc2_pend_cleared", car_pend, 4'b0000);
    cnt = 1;
    while (door_open && cnt < 40) begin
      tick(1);
      if (door_open) cnt++;
    end
    check("cc2_door_cycles", cnt, 8);
    check("cc2_idle", state, IDLE);
    check("cc2_dir", dir_up, 1'b1);

    // asynchronous reset while travelling down
    car_call = 4'b0001;
    tick(1);
    car_call = '0;
    tick(1);
    check("mv_dn_moving", moving, 1'b1);
    check("mv_dn_dir", dir_up, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("arst_floor", floor, 4'b0001);
    check("arst_moving", moving, 1'b0);
    check("arst_dir", dir_up, 1'b1);
    check("arst_car_pend", car_pend, 4'b0000);
    check("arst_state", state, IDLE);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // hall_dn[1] + car_call[3]: pass floor 1, serve 3, return to 1
    hall_dn  = 4'b0010;
    car_call = 4'b1000;
    tick(1);
    hall_dn  = '0;
    car_call = '0;
    check("sc_dn_latched", dn_pend, 4'b0010);
    check("sc_car_latched", car_pend, 4'b1000);
    wait_door(1'b1, "sc_door3_timeout");
    check("sc_first_stop", floor, 4'b1000);
    check("sc_car3_cleared", car_pend, 4'b0000);
    check("sc_dn1_kept", dn_pend, 4'b0010);
    check("sc_dir_top", dir_up, 1'b0);
    wait_door(1'b0, "sc_close3_timeout");
    wait_door(1'b1, "sc_door1_timeout");
    check("sc_second_stop", floor, 4'b0010);
    check("sc_dn1_cleared", dn_pend, 4'b0000);
    check("sc_dir_dn", dir_up, 1'b0);
    wait_door(1'b0, "sc_close1_timeout");

    // hall_up[1] while going up is picked up en route
    do_reset();
    car_call = 4'b1000;
    tick(1);
    car_call = '0;
    tick(1);
    hall_up = 4'b0010;
    tick(1);
    hall_up = '0;
    check("hu_latched", up_pend, 4'b0010);
    wait_door(1'b1, "hu_door1_timeout");
    check("hu_stop_floor", floor, 4'b0010);
    check("hu_cleared", up_pend, 4'b0000);
    check("hu_car_kept", car_pend, 4'b1000);
    wait_door(1'b0, "hu_close1_timeout");
    wait_door(1'b1, "hu_door3_timeout");
    check("hu_then_top", floor, 4'b1000);

    // hall_dn[1] while going up is not served on the way up
    do_reset();
    car_call = 4'b1000;
    tick(1);
    car_call = '0;
    tick(1);
    hall_dn = 4'b0010;
    tick(1);
    hall_dn = '0;
    wait_door(1'b1, "hd_door_timeout");
    check("hd_skip_floor", floor, 4'b1000);
    check("hd_still_pend", dn_pend, 4'b0010);

    // press at the open floor in dwell cycle 6 extends the dwell
    do_reset();
    car_call = 4'b0100;
    tick(1);
    car_call = '0;
    wait_door(1'b1, "dw_door_timeout");
    tick(5);
    car_call = 4'b0100;
    tick(1);
    car_call = '0;
    check("dw_door_held", door_open, 1'b1);
    check("dw_not_latched", car_pend, 4'b0000);
    cnt = 1;
    while (door_open && cnt < 40) begin
      tick(1);
      if (door_open) cnt++;
    end
    check("dw_extra_cycles", cnt, 8);

    // ignored hall bits at the shaft ends
    do_reset();
    hall_up = 4'b1000;
    hall_dn = 4'b0001;
    tick(1);
    hall_up = '0;
    hall_dn = '0;
    check("ign_up_pend", up_pend, 4'b0000);
    check("ign_dn_pend", dn_pend, 4'b0000);
    tick(3);
    check("ign_moving", moving, 1'b0);
    check("ign_state", state, IDLE);

    a2_hall_up = 2'b10;
    a2_hall_dn = 2'b01;
    tick(1);
    a2_hall_up = '0;
    a2_hall_dn = '0;
    check("n2_ign_up", a2_up_pend, 2'b00);
    check("n2_ign_dn", a2_dn_pend, 2'b00);
    tick(2);
    check("n2_ign_moving", a2_moving, 1'b0);
    a2_car_call = 2'b10;
    tick(1);
    a2_car_call = '0;
    cnt = 0;
    while (!a2_door_open && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("n2_door_timeout", a2_door_open, 1'b1);
    check("n2_top_floor", a2_floor, 2'b10);
    check("n2_top_dir", a2_dir_up, 1'b0);

    a8_hall_up = 8'h80;
    a8_hall_dn = 8'h01;
    tick(1);
    a8_hall_up = '0;
    a8_hall_dn = '0;
    check("n8_ign_up", a8_up_pend, 8'h00);
    check("n8_ign_dn", a8_dn_pend, 8'h00);
    a8_hall_dn = 8'h80;
    tick(1);
    a8_hall_dn = '0;
    check("n8_dn7_latched", a8_dn_pend, 8'h80);
    cnt = 0;
    while (!a8_door_open && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("n8_door_timeout", a8_door_open, 1'b1);
    check("n8_top_floor", a8_floor, 8'h80);
    check("n8_top_dir", a8_dir_up, 1'b0);
    check("n8_dn7_cleared", a8_dn_pend, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
# elevator_ctrl_n

Parametrised N-floor elevator controller: latches car and hall call requests, schedules service with a direction-preserving (SCAN) policy, and times floor-to-floor travel and door dwell. It is the next-generation controller for the elevator subsystem, replacing the fixed three-floor FSM. It adds persistent request latching, one-hot position for any floor count, and cycle-counted travel and door timing.

## Interface
- NUM_FLOORS, 4: floor count, ≥2; floor 0 is ground.
- TRAVEL_CYCLES, 4: cycles to move one floor, ≥1.
- DOOR_CYCLES, 8: door-open dwell in cycles, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- car_call  in  NUM_FLOORS  in-car floor buttons, level or pulse, bit i = floor i.
- hall_up  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored.
- hall_dn  in  NUM_FLOORS  hall down buttons; bit 0 ignored.
- floor  out  NUM_FLOORS  one-hot current or last-passed floor.
- door_open  out  1  door open.
- moving  out  1  car travelling between floors.
- dir_up  out  1  current or last direction, 1 = up.
- car_pend, up_pend, dn_pend  out  NUM_FLOORS each  latched pending requests, used to drive button lamps.

## Operation
- Requests: pend |= button each cycle, with ignored bits forced to 0. A bit clears only when its floor is served.
- States: IDLE (door closed, no service), MOVE, DOOR.
- Serve condition at floor f: car_pend[f], or the hall bit of current direction at f, or the opposite-direction hall bit at f when no request exists beyond f in current direction.
- IDLE: if serve condition at f → DOOR. Else if any pending request above f → MOVE, dir_up=1. Else any below → MOVE, dir_up=0. Else stay.
- Direction choice from IDLE, requests both above and below: keep the current dir_up.
- MOVE: a counter runs TRAVEL_CYCLES. On expiry, floor shifts one position in dir and the controller re-evaluates. If the serve condition holds → DOOR. Else if requests remain beyond in dir → continue MOVE. Else → IDLE.
- DOOR: on entry, clear car_pend[f] and the served hall bit(s). Dir_up flips on entry if the opposite hall bit was served. The dwell counter loads DOOR_CYCLES. When the counter reaches 0 → IDLE.
- A press at the current floor during DOOR matching the serve condition is not latched; it reloads the dwell counter.
- floor never leaves the range 0..NUM_FLOORS-1. At floor 0, dir_up is forced to 1. At the top floor, dir_up is forced to 0.
- Reset mid-operation: every pending bit clears and the car is placed at floor 0 with no travel animation.

## Timing
- Reset values: floor = one-hot bit 0, door_open=0, moving=0, dir_up=1, all pend=0, state IDLE.
- Button to pend: 1 cycle, registered.
- Pend to departure from IDLE: 1 cycle. moving rises 1 cycle after pend is visible.
- One-floor trip: moving high exactly TRAVEL_CYCLES cycles. floor updates in the same cycle moving falls or on continue.
- door_open is high for exactly DOOR_CYCLES cycles, plus reloads. Pend clears in the first cycle door_open=1.
- All outputs are registered. No combinational input-to-output path.
- A simultaneous press and clear of the same bit resolves to clear only when DOOR is being entered at that floor.

## Structure
- Package elevator_pkg holds: state enum (IDLE, MOVE, DOOR), counter width function clog2, and the direction constants DIR_UP/DIR_DN.
- Sub-module elevator_req_scan: combinational, given floor, dir and pend vectors, returns req_above, req_below and serve_here. It is parametrised on NUM_FLOORS.
- The top level holds the request registers, FSM, travel and dwell counters, and the position register.

## Test plan
- Reset with NUM_FLOORS=4 → floor=0001, door_open=0, dir_up=1, all pend=0. Assert rst_n low during MOVE → same values immediately.
- car_call[2] pulse at floor 0 → car_pend[2]=1 next cycle. moving=1 for 2×TRAVEL_CYCLES. floor=0100. door_open=1 for 8 cycles. car_pend[2]=0.
- At floor 0 press hall_dn[1] and car_call[3] together → car passes floor 1 without stopping and serves 3. It then reverses, serves hall_dn[1] and clears dn_pend[1].
- hall_up[1] while travelling up from 0 to 3 → stops at 1 with up_pend[1] cleared. hall_dn[1] at the same point → not served on the way up.
- During DOOR at floor 2, press car_call[2] in dwell cycle 6 → door_open stays high 8 more cycles. car_pend[2] stays 0.
- hall_up[3] and hall_dn[0] pressed alone → up_pend and dn_pend stay 0 and the car stays IDLE. Repeat with NUM_FLOORS=2 and 8 to check the top and bottom bounds.
